// File: rtl/sprite_motion_ctrl_pkg.sv
// rtl/sprite_motion_ctrl_pkg.sv - shared enums and default constants for the sprite motion controller
package sprite_motion_ctrl_pkg;

    typedef enum logic [1:0] {
        MODE_STOP  = 2'd0,
        MODE_RIGHT = 2'd1,
        MODE_LEFT  = 2'd2
    } mode_t;

    typedef enum logic [1:0] {
        JS_GROUND = 2'd0,
        JS_UP     = 2'd1,
        JS_DOWN   = 2'd2
    } jump_state_t;

    localparam int DEF_X_W        = 11;
    localparam int DEF_Y_W        = 10;
    localparam int DEF_X_INIT     = 300;
    localparam int DEF_Y_INIT     = 250;
    localparam int DEF_X_MIN      = 0;
    localparam int DEF_X_MAX      = 600;
    localparam int DEF_WALK_SPEED = 2;
    localparam int DEF_JUMP_SPEED = 4;
    localparam int DEF_JUMP_TICKS = 20;
    localparam int DEF_NUM_WALK   = 2;
    localparam int DEF_ANIM_DIV   = 8;

endpackage

// File: rtl/btn_edge_sync.sv
// rtl/btn_edge_sync.sv - two-flop button synchroniser with registered rising-edge pulse
module btn_edge_sync (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic pulse
);

    logic stage1;
    logic stage2;

    // The pulse is registered so a raw rise caught at edge k reaches the consumer at edge k+2.
    always_ff @(posedge clk) begin
        if (reset) begin
            stage1 <= 1'b0;
            stage2 <= 1'b0;
            pulse  <= 1'b0;
        end else begin
            stage1 <= raw;
            stage2 <= stage1;
            pulse  <= stage1 & ~stage2;
        end
    end

endmodule

// File: rtl/sprite_motion_ctrl.sv
// rtl/sprite_motion_ctrl.sv - sprite walk/jump motion controller with walk animation
module sprite_motion_ctrl
    import sprite_motion_ctrl_pkg::*;
#(
    parameter int X_W        = DEF_X_W,
    parameter int Y_W        = DEF_Y_W,
    parameter int X_INIT     = DEF_X_INIT,
    parameter int Y_INIT     = DEF_Y_INIT,
    parameter int X_MIN      = DEF_X_MIN,
    parameter int X_MAX      = DEF_X_MAX,
    parameter int WALK_SPEED = DEF_WALK_SPEED,
    parameter int JUMP_SPEED = DEF_JUMP_SPEED,
    parameter int JUMP_TICKS = DEF_JUMP_TICKS,
    parameter int NUM_WALK   = DEF_NUM_WALK,
    parameter int ANIM_DIV   = DEF_ANIM_DIV
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  frame_tick,
    input  logic                  right_raw,
    input  logic                  left_raw,
    input  logic                  stop_raw,
    input  logic                  jump_raw,
    output logic signed [X_W-1:0] pos_x,
    output logic signed [Y_W-1:0] pos_y,
    output logic [NUM_WALK:0]     frame_vis,
    output logic                  jumping,
    output logic                  jump_done
);

    localparam int CNT_W  = (JUMP_TICKS > 1) ? $clog2(JUMP_TICKS) : 1;
    localparam int ANIM_W = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
    localparam int IDX_W  = (NUM_WALK > 1) ? $clog2(NUM_WALK) : 1;

    localparam logic signed [X_W:0]   X_MIN_E  = (X_W+1)'(X_MIN);
    localparam logic signed [X_W:0]   X_MAX_E  = (X_W+1)'(X_MAX);
    localparam logic signed [X_W:0]   WALK_E   = (X_W+1)'(WALK_SPEED);
    localparam logic signed [Y_W-1:0] YSPD_E   = Y_W'(JUMP_SPEED);
    localparam logic signed [Y_W-1:0] Y_INIT_E = Y_W'(Y_INIT);

    logic right_pulse, left_pulse, stop_pulse, jump_pulse;

    btn_edge_sync u_right (.clk(clk), .reset(reset), .raw(right_raw), .pulse(right_pulse));
    btn_edge_sync u_left  (.clk(clk), .reset(reset), .raw(left_raw),  .pulse(left_pulse));
    btn_edge_sync u_stop  (.clk(clk), .reset(reset), .raw(stop_raw),  .pulse(stop_pulse));
    btn_edge_sync u_jump  (.clk(clk), .reset(reset), .raw(jump_raw),  .pulse(jump_pulse));

    mode_t                 mode_q, mode_d;
    jump_state_t           js_q, js_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  land;
    logic signed [Y_W-1:0] y_d;
    logic signed [X_W:0]   vx, x_sum;
    logic signed [X_W-1:0] x_next;
    logic [ANIM_W-1:0]     anim_cnt, anim_cnt_d;
    logic [IDX_W-1:0]      walk_idx, walk_idx_d;
    logic [NUM_WALK:0]     vis_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            js_q  <= JS_GROUND;
            cnt_q <= '0;
        end else begin
            js_q  <= js_d;
            cnt_q <= cnt_d;
        end
    end

    // Vertical motion is driven by the jump FSM; landing snaps back to the ground line.
    always_comb begin
        js_d  = js_q;
        cnt_d = cnt_q;
        land  = 1'b0;
        y_d   = pos_y;
        case (js_q)
            JS_GROUND: begin
                if (jump_pulse) begin
                    js_d  = JS_UP;
                    cnt_d = '0;
                end
            end
            JS_UP: begin
                if (frame_tick) begin
                    y_d = pos_y - YSPD_E;
                    if (cnt_q == CNT_W'(JUMP_TICKS-1)) begin
                        js_d  = JS_DOWN;
                        cnt_d = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            JS_DOWN: begin
                if (frame_tick) begin
                    if (cnt_q == CNT_W'(JUMP_TICKS-1)) begin
                        js_d  = JS_GROUND;
                        cnt_d = '0;
                        land  = 1'b1;
                        y_d   = Y_INIT_E;
                    end else begin
                        y_d   = pos_y + YSPD_E;
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                js_d  = JS_GROUND;
                cnt_d = '0;
            end
        endcase
    end

    always_comb begin
        case (mode_q)
            MODE_RIGHT: vx = WALK_E;
            MODE_LEFT:  vx = -WALK_E;
            default:    vx = '0;
        endcase
        x_sum = {pos_x[X_W-1], pos_x} + vx;
        if (x_sum < X_MIN_E) begin
            x_next = X_MIN_E[X_W-1:0];
        end else if (x_sum > X_MAX_E) begin
            x_next = X_MAX_E[X_W-1:0];
        end else begin
            x_next = x_sum[X_W-1:0];
        end

        mode_d = mode_q;
        if (right_pulse) begin
            mode_d = MODE_RIGHT;
        end else if (left_pulse) begin
            mode_d = MODE_LEFT;
        end else if (stop_pulse) begin
            mode_d = MODE_STOP;
        end
    end

    // Animation uses the mode in force before this edge, but the jump state after it,
    // so the landing tick already shows the walk/stop frame.
    always_comb begin
        anim_cnt_d = anim_cnt;
        walk_idx_d = walk_idx;
        vis_d      = '0;
        if (mode_q == MODE_STOP) begin
            anim_cnt_d = '0;
            walk_idx_d = '0;
        end else if (anim_cnt == ANIM_W'(ANIM_DIV-1)) begin
            anim_cnt_d = '0;
            walk_idx_d = (walk_idx == IDX_W'(NUM_WALK-1)) ? '0 : walk_idx + IDX_W'(1);
        end else begin
            anim_cnt_d = anim_cnt + ANIM_W'(1);
        end

        if (js_d != JS_GROUND) begin
            vis_d[NUM_WALK] = 1'b1;
        end else if (mode_q == MODE_STOP) begin
            vis_d[0] = 1'b1;
        end else begin
            for (int i = 0; i < NUM_WALK; i++) begin
                vis_d[i] = (walk_idx_d == IDX_W'(i));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q    <= MODE_STOP;
            pos_x     <= X_W'(X_INIT);
            pos_y     <= Y_INIT_E;
            anim_cnt  <= '0;
            walk_idx  <= '0;
            frame_vis <= (NUM_WALK+1)'(1);
            jumping   <= 1'b0;
            jump_done <= 1'b0;
        end else begin
            mode_q    <= mode_d;
            pos_y     <= y_d;
            jumping   <= (js_d != JS_GROUND);
            jump_done <= land;
            if (frame_tick) begin
                pos_x     <= x_next;
                anim_cnt  <= anim_cnt_d;
                walk_idx  <= walk_idx_d;
                frame_vis <= vis_d;
            end
        end
    end

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// tb/tb_sprite_motion_ctrl.sv - scoreboard bench for sprite_motion_ctrl against a behavioural model
module tb_sprite_motion_ctrl;

    localparam int X_W = 11, Y_W = 10, X_INIT = 300, Y_INIT = 250, X_MIN = 0, X_MAX = 600;
    localparam int WS = 2, JS = 4, JT = 20, NW = 2, AD = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic frame_tick = 1'b0;
    logic right_raw = 1'b0, left_raw = 1'b0, stop_raw = 1'b0, jump_raw = 1'b0;
    logic signed [X_W-1:0] pos_x;
    logic signed [Y_W-1:0] pos_y;
    logic [NW:0] frame_vis;
    logic jumping, jump_done;

    always #5 clk = ~clk;

    sprite_motion_ctrl #(
        .X_W(X_W), .Y_W(Y_W), .X_INIT(X_INIT), .Y_INIT(Y_INIT), .X_MIN(X_MIN), .X_MAX(X_MAX),
        .WALK_SPEED(WS), .JUMP_SPEED(JS), .JUMP_TICKS(JT), .NUM_WALK(NW), .ANIM_DIV(AD)
    ) dut (
        .clk(clk), .reset(reset), .frame_tick(frame_tick),
        .right_raw(right_raw), .left_raw(left_raw), .stop_raw(stop_raw), .jump_raw(jump_raw),
        .pos_x(pos_x), .pos_y(pos_y), .frame_vis(frame_vis),
        .jumping(jumping), .jump_done(jump_done)
    );

    typedef struct {
        int x;
        int y;
        int vis;
        bit jmp;
        bit done;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int n_cmp = 0;
    int n_bad = 0;

    bit r_right, r_left, r_stop, r_jump;

    // Model: airborne flag plus elapsed jump ticks; height is a triangle over 2*JT ticks.
    int m_x, m_y, m_mode, m_vis, m_walk, m_jt;
    bit m_air, m_done;
    bit [3:0] raw_prev, d1, d2;

    task automatic model_edge(input bit tick, input bit rst, input bit [3:0] raw);
        bit [3:0] eff;
        bit was_air;
        int v;
        if (rst) begin
            m_x = X_INIT; m_y = Y_INIT; m_mode = 0; m_air = 1'b0; m_jt = 0;
            m_walk = 0; m_vis = 1; m_done = 1'b0;
            raw_prev = '0; d1 = '0; d2 = '0;
        end else begin
            eff = d2;
            d2 = d1;
            d1 = raw & ~raw_prev;
            raw_prev = raw;
            was_air = m_air;
            m_done = 1'b0;
            if (tick) begin
                v = (m_mode == 1) ? WS : (m_mode == 2) ? -WS : 0;
                m_x = m_x + v;
                if (m_x < X_MIN) m_x = X_MIN;
                if (m_x > X_MAX) m_x = X_MAX;
                if (m_air) begin
                    m_jt++;
                    if (m_jt == 2*JT) begin
                        m_air = 1'b0;
                        m_done = 1'b1;
                    end
                end
                m_walk = (m_mode == 0) ? 0 : m_walk + 1;
            end
            if (eff[3] && !was_air) begin
                m_air = 1'b1;
                m_jt = 0;
            end
            m_y = m_air ? Y_INIT - JS*((m_jt <= JT) ? m_jt : 2*JT - m_jt) : Y_INIT;
            if (tick) m_vis = m_air ? (1 << NW) : (m_mode == 0) ? 1 : (1 << ((m_walk / AD) % NW));
            if (eff[0]) m_mode = 1;
            else if (eff[1]) m_mode = 2;
            else if (eff[2]) m_mode = 0;
        end
    endtask

    task automatic step(input bit tick, input bit rst);
        exp_t e;
        @(negedge clk);
        frame_tick = tick;
        reset = rst;
        right_raw = r_right;
        left_raw = r_left;
        stop_raw = r_stop;
        jump_raw = r_jump;
        model_edge(tick, rst, {r_jump, r_stop, r_left, r_right});
        e.x = m_x; e.y = m_y; e.vis = m_vis; e.jmp = m_air; e.done = m_done;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0);
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            step(1'b1, 1'b0);
            step(1'b0, 1'b0);
        end
    endtask

    task automatic do_reset();
        r_right = 0; r_left = 0; r_stop = 0; r_jump = 0;
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string nm, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", nm, got, want);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            n_cmp++;
            if (int'(pos_x) != mon_e.x || int'(pos_y) != mon_e.y || int'(frame_vis) != mon_e.vis ||
                jumping != mon_e.jmp || jump_done != mon_e.done) begin
                n_bad++;
                $display("FAIL state t=%0t: got x=%0d y=%0d vis=%b jmp=%b done=%b want x=%0d y=%0d vis=%0d jmp=%b done=%b",
                         $time, pos_x, pos_y, frame_vis, jumping, jump_done,
                         mon_e.x, mon_e.y, mon_e.vis, mon_e.jmp, mon_e.done);
            end
        end
    end

    initial begin
        do_reset();
        settle();
        chk("reset_x", int'(pos_x), 300);
        chk("reset_y", int'(pos_y), 250);
        chk("reset_vis", int'(frame_vis), 1);
        chk("reset_jumping", int'(jumping), 0);

        r_right = 1; idle(3); ticks(10); settle();
        chk("walk_right_x", int'(pos_x), 320);
        chk("walk_right_vis", int'(frame_vis), 2);

        do_reset();
        r_jump = 1; idle(3); ticks(20); settle();
        chk("jump_apex_y", int'(pos_y), 170);
        chk("jump_apex_jumping", int'(jumping), 1);
        ticks(20); settle();
        chk("jump_land_y", int'(pos_y), 250);
        chk("jump_land_jumping", int'(jumping), 0);

        do_reset();
        r_left = 1; idle(3); ticks(160); settle();
        chk("left_clamp_x", int'(pos_x), 0);

        do_reset();
        r_jump = 1; idle(3); ticks(5);
        r_jump = 0; idle(1); r_jump = 1; idle(3);
        ticks(34); settle();
        chk("rejump_airborne", int'(jumping), 1);
        ticks(1); settle();
        chk("rejump_land_y", int'(pos_y), 250);
        chk("rejump_land_jumping", int'(jumping), 0);

        do_reset();
        r_jump = 1; idle(3); ticks(10);
        step(1'b0, 1'b1); settle();
        chk("abort_y", int'(pos_y), 250);
        chk("abort_jumping", int'(jumping), 0);
        chk("abort_vis", int'(frame_vis), 1);

        do_reset();
        r_right = 1; r_left = 1; idle(3); ticks(4); settle();
        chk("right_wins_x", int'(pos_x), 308);
        r_stop = 1; idle(3); ticks(4); settle();
        chk("stop_frozen_x", int'(pos_x), 308);
        chk("stop_vis", int'(frame_vis), 1);

        do_reset();
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 15) == 0) r_right = ~r_right;
            if ($urandom_range(0, 15) == 0) r_left = ~r_left;
            if ($urandom_range(0, 23) == 0) r_stop = ~r_stop;
            if ($urandom_range(0, 11) == 0) r_jump = ~r_jump;
            step($urandom_range(0, 2) == 0, $urandom_range(0, 799) == 0);
        end

        repeat (2) @(posedge clk);
        #2;
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sprite_motion_ctrl.md
SPRITE_MOTION_CTRL -- requirements
Module: sprite_motion_ctrl

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- X_W, 11, signed x-position width
- Y_W, 10, signed y-position width
- X_INIT, 300, reset/left-origin x
- Y_INIT, 250, reset/ground y
- X_MIN, 0, left clamp bound
- X_MAX, 600, right clamp bound
- WALK_SPEED, 2, pixels per frame tick horizontally
- JUMP_SPEED, 4, pixels per frame tick vertically
- JUMP_TICKS, 20, frame ticks per jump phase (up or down), ≥1
- NUM_WALK, 2, walk animation frames, ≥1
- ANIM_DIV, 8, frame ticks per walk-frame advance, ≥1
REQ-002 Ports (name, direction, width, meaning), one per line:
- clk, in, 1, sole clock
- reset, in, 1, synchronous active-high reset
- frame_tick, in, 1, one-cycle pulse at raster origin (H=0,V=0)
- right_raw, left_raw, stop_raw, jump_raw, in, 1 each, asynchronous button levels
- pos_x, out, X_W, signed sprite left coordinate
- pos_y, out, Y_W, signed sprite top coordinate
- frame_vis, out, NUM_WALK+1, one-hot sprite visibility; bit NUM_WALK = jump frame
- jumping, out, 1, high while the jump FSM is not in GROUND
- jump_done, out, 1, one-cycle pulse on landing

Function
REQ-003 Each raw input SHALL pass through a two-flop synchroniser; rising-edge pulse = stage1 & ~stage2; a raw rise sampled at edge k SHALL affect registered state at edge k+2.
REQ-004 Horizontal mode register {STOP, RIGHT, LEFT}: right pulse → RIGHT, else left pulse → LEFT, else stop pulse → STOP (priority right > left > stop).
REQ-005 vx SHALL be +WALK_SPEED (RIGHT), −WALK_SPEED (LEFT), 0 (STOP).
REQ-006 pos_x SHALL update only on frame_tick cycles: x_next = x + vx, computed in X_W+1 signed bits, clamped to [X_MIN, X_MAX].
REQ-007 Jump FSM states GROUND, UP, DOWN; jump pulse in GROUND → UP with tick counter 0; jump pulses in UP/DOWN SHALL be ignored.
REQ-008 In UP, each frame_tick: pos_y −= JUMP_SPEED, counter++; the tick where the counter = JUMP_TICKS−1 SHALL move the FSM to DOWN and clear the counter.
REQ-009 In DOWN, each frame_tick: pos_y += JUMP_SPEED, counter++; the tick where the counter = JUMP_TICKS−1 SHALL move the FSM to GROUND and pulse jump_done for exactly one cycle.
REQ-010 On landing, pos_y SHALL equal Y_INIT exactly; in GROUND, pos_y SHALL stay constant.
REQ-011 Horizontal motion SHALL continue independently during a jump; jump and direction pulses in the same cycle SHALL both take effect.
REQ-012 Animation, evaluated on frame_tick:
- jumping → frame_vis bit NUM_WALK only
- else STOP → bit 0 only
- else walk index advances every ANIM_DIV ticks, modulo NUM_WALK; bit walk_index set
REQ-013 On landing, frame_vis SHALL revert to bit 0 (STOP) or the current walk index in the same cycle jump_done is high.
REQ-014 frame_vis SHALL be exactly one-hot in every cycle after reset.
REQ-015 All outputs SHALL be registered.
REQ-016 A frame_tick coinciding with a button pulse SHALL apply the motion from the previous mode; the new mode SHALL apply from the next tick.

Reset
REQ-017 On reset:
- pos_x=X_INIT, pos_y=Y_INIT
- mode=STOP, FSM=GROUND
- counters 0, walk index 0
- frame_vis=1 (bit 0), jumping=0, jump_done=0
- synchroniser flops 0
REQ-018 Reset mid-jump SHALL abort the jump with no jump_done pulse.

Structure
REQ-019 A shared package SHALL hold the mode and jump-state enumerations plus default speed and bound constants.
REQ-020 One sub-module, btn_edge_sync (2-flop sync + rising-edge pulse), SHALL be instantiated four times.

Verification
REQ-021 Right press, 10 frame ticks → pos_x=320, frame_vis alternates 01/10 every 8 ticks (NUM_WALK=2).
REQ-022 Jump from ground → pos_y reaches 170 after 20 ticks, returns to 250 after 40, jump_done pulses once, jumping high 40 ticks.
REQ-023 Left held from x=300, 160 ticks → pos_x clamps at 0 and stays.
REQ-024 Second jump press at tick 5 of a jump → ignored, landing still at tick 40.
REQ-025 Reset asserted at tick 10 of a jump → pos_y=250, jumping=0, frame_vis=001, no jump_done.
REQ-026 Right and left pulses in the same cycle → mode RIGHT; stop press → pos_x frozen, frame_vis=001.
